// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing a single-port on-chip memory between NUM_REQ requesters.
// Sequences the memory's multi-cycle read and returns data with a one-cycle response pulse.
module onchip_mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        busy,
    output logic                        mem_wr_en,
    output logic                        mem_rd_en,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_use_ext_addr,
    output logic                        mem_multi_cycle,
    output logic [1:0]                  mem_cycle_count,
    input  logic [DATA_W-1:0]           mem_rdata
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    last_grant_q;
    logic [IDX_W-1:0]    owner_q;
    logic [1:0]          wait_cnt_q;
    logic                mem_wr_en_q;
    logic                mem_rd_en_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;

    logic [IDX_W-1:0]    grant_d;
    logic                grant_vld_d;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_d     = last_grant_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_vld_d && req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
                grant_vld_d = 1'b1;
                grant_d     = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready = (state_q == IDLE && grant_vld_d) ? (NUM_REQ'(1) << grant_d) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
            wait_cnt_q   <= '0;
            mem_wr_en_q  <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp_valid_q  <= '0;
        end else begin
            mem_wr_en_q <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        last_grant_q <= grant_d;
                        owner_q      <= grant_d;
                        wait_cnt_q   <= '0;
                        mem_addr_q   <= req_addr[grant_d*ADDR_W +: ADDR_W];
                        mem_wdata_q  <= req_wdata[grant_d*DATA_W +: DATA_W];
                        if (req_write[grant_d]) begin
                            state_q     <= WR;
                            mem_wr_en_q <= 1'b1;
                        end else begin
                            state_q     <= RD;
                            mem_rd_en_q <= 1'b1;
                        end
                    end
                end
                WR: state_q <= IDLE;
                // Holding rd_en for RD_WAIT+1 cycles walks the memory's counter back to 0.
                RD: begin
                    if (wait_cnt_q == 2'(RD_WAIT)) begin
                        mem_rd_en_q <= 1'b0;
                        rsp_valid_q <= NUM_REQ'(1) << owner_q;
                        state_q     <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy             = (state_q != IDLE);
    assign mem_wr_en        = mem_wr_en_q;
    assign mem_rd_en        = mem_rd_en_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = mem_rdata;
    assign mem_use_ext_addr = 1'b1;
    assign mem_multi_cycle  = (RD_WAIT != 0);
    assign mem_cycle_count  = 2'(RD_WAIT);
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: three instances (RD_WAIT 0/2/3), each with its own memory model.
module tb_onchip_mem_arbiter;
    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int WAITS [3] = '{0, 2, 3};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    rv [3], rw [3], rdy [3], rsp [3];
    logic [N*AW-1:0] ra [3];
    logic [N*DW-1:0] rwd [3];
    logic [DW-1:0]   rdat [3], mwd [3], mrd [3];
    logic [AW-1:0]   ma [3];
    logic            bsy [3], wr [3], rd [3], ext [3], mc [3];
    logic [1:0]      cc [3];

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 3; g++) begin : inst
        onchip_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(WAITS[g])) dut (
            .clk(clk), .reset_n(reset_n),
            .req_valid(rv[g]), .req_write(rw[g]), .req_addr(ra[g]), .req_wdata(rwd[g]),
            .req_ready(rdy[g]), .rsp_valid(rsp[g]), .rsp_rdata(rdat[g]), .busy(bsy[g]),
            .mem_wr_en(wr[g]), .mem_rd_en(rd[g]), .mem_addr(ma[g]), .mem_wdata(mwd[g]),
            .mem_use_ext_addr(ext[g]), .mem_multi_cycle(mc[g]), .mem_cycle_count(cc[g]),
            .mem_rdata(mrd[g])
        );

        // Memory model: registered output, loaded when the cycle counter reaches cycle_count.
        logic [DW-1:0] mem [1024];
        logic [1:0]    cnt;
        logic [DW-1:0] dout;
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt  <= 2'd0;
                dout <= '0;
            end else begin
                if (wr[g]) mem[ma[g]] <= mwd[g];
                if (rd[g]) begin
                    if (!mc[g] || cnt == cc[g]) begin
                        dout <= mem[ma[g]];
                        cnt  <= 2'd0;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
            end
        end
        assign mrd[g] = dout;
    end

    typedef struct {
        logic [N-1:0] vld;
        logic [N-1:0] exp_rdy;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic wait_ready(input int k, input int r, output bit ok);
        ok = 1'b0;
        #1;
        for (int t = 0; t < 20; t++) begin
            if (rdy[k][r]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_write(input int k, input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        rw[k][r] = 1'b1;
        ra[k][r*AW +: AW] = a;
        rwd[k][r*DW +: DW] = d;
        rv[k][r] = 1'b1;
        wait_ready(k, r, ok);
        chk($sformatf("wr_accept_i%0d", k), 32'(ok), 1);
        tick();
        rv[k][r] = 1'b0;
        chk($sformatf("wr_en_i%0d", k), 32'(wr[k]), 1);
        chk($sformatf("wr_noread_i%0d", k), 32'(rd[k]), 0);
        chk($sformatf("wr_addr_i%0d", k), 32'(ma[k]), 32'(a));
        chk($sformatf("wr_data_i%0d", k), 32'(mwd[k]), 32'(d));
        tick();
        chk($sformatf("wr_done_i%0d", k), 32'({wr[k], bsy[k]}), 0);
    endtask

    task automatic do_read(input int k, input int r, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bit ok;
        int lat, rdc;
        logic ov;
        rw[k][r] = 1'b0;
        ra[k][r*AW +: AW] = a;
        rv[k][r] = 1'b1;
        wait_ready(k, r, ok);
        chk($sformatf("rd_accept_i%0d", k), 32'(ok), 1);
        tick();
        rv[k][r] = 1'b0;
        lat = 1;
        rdc = 0;
        ov  = 1'b0;
        while (lat < 20) begin
            if (rd[k]) rdc++;
            ov = ov | (rd[k] & wr[k]);
            if (rsp[k] != 0) break;
            tick();
            lat++;
        end
        chk($sformatf("rd_latency_i%0d", k), 32'(lat), 32'(WAITS[k] + 2));
        chk($sformatf("rd_en_cycles_i%0d", k), 32'(rdc), 32'(WAITS[k] + 1));
        chk($sformatf("rsp_onehot_i%0d", k), 32'(rsp[k]), 32'(1 << r));
        chk($sformatf("rsp_data_i%0d", k), 32'(rdat[k]), 32'(exp));
        chk($sformatf("rd_wr_overlap_i%0d", k), 32'(ov), 0);
        tick();
        chk($sformatf("rsp_pulse_end_i%0d", k), 32'(rsp[k]), 0);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [13];
        int gl [4];
        int ng, nr, gi;
        logic coinc;
        logic [DW-1:0] dtab [3];

        for (int k = 0; k < 3; k++) begin
            rv[k] = '0; rw[k] = '0; ra[k] = '0; rwd[k] = '0;
        end

        // Starts with last_grant = 2, ends with last_grant = 1.
        vecs[0]  = '{3'b111, 3'b001};
        vecs[1]  = '{3'b111, 3'b010};
        vecs[2]  = '{3'b111, 3'b100};
        vecs[3]  = '{3'b111, 3'b001};
        vecs[4]  = '{3'b100, 3'b100};
        vecs[5]  = '{3'b011, 3'b001};
        vecs[6]  = '{3'b101, 3'b100};
        vecs[7]  = '{3'b010, 3'b010};
        vecs[8]  = '{3'b000, 3'b000};
        vecs[9]  = '{3'b001, 3'b001};
        vecs[10] = '{3'b110, 3'b010};
        vecs[11] = '{3'b110, 3'b100};
        vecs[12] = '{3'b110, 3'b010};
        dtab[0] = 16'h1111; dtab[1] = 16'h2222; dtab[2] = 16'h3333;

        // Reset values
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready_i%0d", k), 32'(rdy[k]), 0);
            chk($sformatf("rst_rsp_i%0d", k), 32'(rsp[k]), 0);
            chk($sformatf("rst_ctl_i%0d", k), 32'({bsy[k], wr[k], rd[k]}), 0);
            chk($sformatf("rst_addr_data_i%0d", k), 32'({ma[k], mwd[k]}), 0);
            chk($sformatf("rst_rdata_i%0d", k), 32'(rdat[k]), 0);
            chk($sformatf("const_ext_i%0d", k), 32'(ext[k]), 1);
            chk($sformatf("const_mc_i%0d", k), 32'(mc[k]), 32'(WAITS[k] != 0));
            chk($sformatf("const_cc_i%0d", k), 32'(cc[k]), 32'(WAITS[k]));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // Three requesters holding reads: grant order 0,1,2,0
        for (int i = 0; i < 3; i++) do_write(0, 0, AW'(i + 1), dtab[i]);
        pulse_reset();
        ra[0] = {10'h003, 10'h002, 10'h001};
        rw[0] = 3'b000;
        rv[0] = 3'b111;
        #1;
        ng = 0; nr = 0; coinc = 1'b0;
        for (int t = 0; t < 40 && nr < 4; t++) begin
            if (rdy[0] != 0 && rsp[0] != 0) coinc = 1'b1;
            if (rdy[0] != 0 && ng < 4) begin
                gl[ng] = oh2i(rdy[0]);
                ng++;
            end
            if (rsp[0] != 0) begin
                gi = (nr < ng) ? gl[nr] : 0;
                chk($sformatf("rr3_rsp%0d", nr), 32'(rsp[0]), 32'(1 << gi));
                chk($sformatf("rr3_data%0d", nr), 32'(rdat[0]), 32'(dtab[gi]));
                nr++;
                if (nr == 4) rv[0] = '0;
            end
            if (nr < 4) tick();
        end
        chk("rr3_nrsp", 32'(nr), 4);
        chk("rr3_ngrant", 32'(ng), 4);
        for (int i = 0; i < 4 && i < ng; i++) chk($sformatf("rr3_grant%0d", i), 32'(gl[i]), 32'(i % 3));
        chk("rr3_ready_rsp_coincide", 32'(coinc), 0);
        tick();

        // req1/req2 continuous writes: alternating 1,2,1,2
        ra[0] = {10'h202, 10'h201, 10'h200};
        rw[0] = 3'b110;
        rv[0] = 3'b110;
        #1;
        ng = 0;
        for (int t = 0; t < 30 && ng < 4; t++) begin
            if (rdy[0] != 0) begin
                gl[ng] = oh2i(rdy[0]);
                ng++;
            end
            if (ng < 4) tick();
        end
        tick();
        rv[0] = '0;
        tick();
        chk("rr2_ngrant", 32'(ng), 4);
        for (int i = 0; i < 4 && i < ng; i++) chk($sformatf("rr2_grant%0d", i), 32'(gl[i]), 32'(1 + i % 2));

        // Arbitration vectors (all writes)
        ra[0]  = {10'h102, 10'h101, 10'h100};
        rwd[0] = {16'hC002, 16'hC001, 16'hC000};
        rw[0]  = 3'b111;
        for (int v = 0; v < 13; v++) begin
            rv[0] = vecs[v].vld;
            #1;
            chk($sformatf("vec%0d_ready", v), 32'(rdy[0]), 32'(vecs[v].exp_rdy));
            tick();
            rv[0] = '0;
            if (vecs[v].exp_rdy != 0) begin
                chk($sformatf("vec%0d_wr_en", v), 32'(wr[0]), 1);
                chk($sformatf("vec%0d_addr", v), 32'(ma[0]), 32'(10'h100 + 10'(oh2i(vecs[v].exp_rdy))));
            end else begin
                chk($sformatf("vec%0d_idle", v), 32'({wr[0], rd[0], bsy[0]}), 0);
            end
            tick();
        end

        // RD_WAIT=0 write then read
        do_write(0, 0, 10'h010, 16'hA5A5);
        do_read(0, 0, 10'h010, 16'hA5A5);

        // Back-to-back write (req1) then read (req2) at 0x3FF
        ra[0][1*AW +: AW] = 10'h3FF;
        ra[0][2*AW +: AW] = 10'h3FF;
        rwd[0][1*DW +: DW] = 16'hFFFF;
        rw[0] = 3'b010;
        rv[0] = 3'b110;
        #1;
        chk("b2b_grant_wr", 32'(rdy[0]), 32'h2);
        tick();
        rv[0][1] = 1'b0;
        chk("b2b_wr_phase", 32'({wr[0], rd[0]}), 32'h2);
        tick();
        chk("b2b_grant_rd", 32'(rdy[0]), 32'h4);
        tick();
        rv[0] = '0;
        chk("b2b_rd_phase", 32'({wr[0], rd[0]}), 32'h1);
        tick();
        chk("b2b_rsp", 32'(rsp[0]), 32'h4);
        chk("b2b_data", 32'(rdat[0]), 32'hFFFF);
        chk("b2b_rsp_nord", 32'({wr[0], rd[0]}), 0);
        tick();

        // RD_WAIT=2: two reads, second confirms counter realignment
        do_write(1, 0, 10'h020, 16'h1357);
        do_read(1, 0, 10'h020, 16'h1357);
        do_write(1, 2, 10'h021, 16'h2468);
        do_read(1, 2, 10'h021, 16'h2468);

        // RD_WAIT=3: reset during read wait cycle 1
        do_write(2, 0, 10'h3FF, 16'hBEEF);
        ra[2][0 +: AW] = 10'h3FF;
        rw[2] = '0;
        rv[2] = 3'b001;
        #1;
        chk("rst_mid_accept", 32'(rdy[2]), 1);
        tick();
        rv[2] = '0;
        chk("rst_mid_rd0", 32'(rd[2]), 1);
        tick();
        chk("rst_mid_rd1", 32'(rd[2]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_ready", 32'(rdy[2]), 0);
        chk("rst_async_rsp", 32'(rsp[2]), 0);
        chk("rst_async_ctl", 32'({bsy[2], wr[2], rd[2]}), 0);
        chk("rst_async_addr_data", 32'({ma[2], mwd[2]}), 0);
        chk("rst_async_rdata", 32'(rdat[2]), 0);
        tick();
        chk("rst_hold_rsp", 32'(rsp[2]), 0);
        reset_n = 1'b1;
        tick();
        chk("rst_after_rsp", 32'({rsp[2], bsy[2]}), 0);
        ra[2][1*AW +: AW] = 10'h3FF;
        rv[2] = 3'b011;
        #1;
        chk("rst_after_first_grant", 32'(rdy[2]), 1);
        rv[2] = '0;
        do_read(2, 0, 10'h3FF, 16'hBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
